i2s_transmitter: RTL
====================

# i2s_transmitter

Playback-side counterpart of the I2S receiver. Accepts 32-bit PCM words on an AXI-Stream slave port, buffers one stereo frame, and serialises it MSB-first onto `sd` in Philips I2S format. `sck` and `ws` come from the shared `i2s_controller`, which runs in the same `s_axis_aclk` domain. The block drives audio out to the DAC/amp path.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: bits per slot. Equals the `tdata` width.

Ports:
- `s_axis_aclk`, in, 1: system clock. The only clock.
- `s_axis_aresetn`, in, 1: reset, asynchronous, active-low.
- `s_axis_tvalid`, in, 1: the upstream word is valid.
- `s_axis_tready`, out, 1: the block can accept a word.
- `s_axis_tdata`, in, DATA_WIDTH: PCM sample, two's complement.
- `s_axis_tlast`, in, 1: marks the right-channel word, the second beat of a frame.
- `sck`, in, 1: I2S bit clock from the controller, synchronous to `s_axis_aclk`.
- `ws`, in, 1: word select from the controller. 0 = left, 1 = right.
- `sd`, out, 1: serial data to the DAC.
- `underflow`, out, 1: one-clock pulse when a left slot starts with no full frame buffered.
- `misalign`, out, 1: one-clock pulse when a beat is dropped for a `tlast` error.

## Operation

**Edge detection.** Register `sck_q`. A bit event is `fall = sck_q & ~sck`. `ws` is sampled only on `fall`, into `ws_last`.

**Input buffer (`next_left`, `next_right`, `fill` state).**
- EMPTY: a handshake with `tlast=0` stores `next_left` and moves to HALF. A handshake with `tlast=1` drops the beat, pulses `misalign`, and stays EMPTY.
- HALF: any handshake stores `next_right` and moves to FULL. If `tlast=0`, the word is still stored and `misalign` pulses.
- FULL: `s_axis_tready=0`.
- In EMPTY and HALF, `s_axis_tready=1`.

**Play registers and sync.**
- `play_left` and `play_right` hold the frame being shifted.
- `synced` is cleared by reset. It sets on the first `fall` where `ws_last=1` and `ws=0`.
- Until `synced` is set, `sd` stays 0, nothing loads, and `underflow` stays low.

**Per `fall`, once synced:**
- Left frame start (`ws_last=1`, `ws=0`):
  - If `fill`=FULL: copy `next_*` to `play_*` and set `fill`=EMPTY.
  - Otherwise: set `play_*` to 0 and pulse `underflow`.
  - Set `load_pending`, channel = left.
- Right slot start (`ws_last=0`, `ws=1`): set `load_pending`, channel = right.
- Bit output:
  - If `load_pending` was set at the previous `fall`: `sd` <= word[DATA_WIDTH-1] of the selected channel, and the shift register takes word << 1.
  - Otherwise: `sd` <= shreg MSB, and shreg shifts left, filling with 0.
- Effect: the LSB of the previous word goes out on the `fall` that coincides with the `ws` change. The MSB follows one `sck` period later, which gives the standard I2S one-bit delay.
- Slots longer than DATA_WIDTH bits pad with 0.

**Simultaneous events.**
- A left-frame-start `fall` and an input handshake that completes FULL in the same clock: the frame just completed is not consumed. It waits for the next frame.
- A copy to play (`fill` <- EMPTY) and a new handshake in the same clock: the handshake is evaluated against the pre-copy state (FULL, so `tready=0`). No data is lost.

**Reset (asserting at any time, including mid-word):**
- `sd`=0, `s_axis_tready`=0, `underflow`=0, `misalign`=0.
- `fill`=EMPTY. `play_*`, `next_*` and shreg are 0. `synced`=0, `load_pending`=0, `sck_q`=0, `ws_last`=0.

## Timing

- `sd` updates on the clock edge after the cycle in which `fall` is detected, so it trails the `sck` falling edge by 1–2 clocks. This is well inside half an `sck` period; the DAC samples on the rising edge.
- `sck` high and low phases must each be at least 2 clocks.
- `s_axis_tready` is registered-free combinational from `fill`. It goes 1 on the first clock after reset release.
- First-word latency: a frame completed before a left frame start has its MSB on `sd` 1 `sck` period after that start.
- Throughput: one frame per `ws` period. The buffer admits the next frame while the current one plays.

## Test plan

- **Reset.** Hold `s_axis_aresetn=0` with the controller running.
  - `sd`, `underflow`, `misalign` and `tready` are 0.
  - `tready` is 1 one clock after release.
- **Single frame.** Send left=0xA5A5_0001 (`tlast=0`), then right=0x8000_00FF (`tlast=1`).
  - After sync, `sd` at successive `sck` rises equals those 64 bits MSB-first.
  - Each word's MSB appears 1 `sck` after the `ws` edge.
  - Loopback into `i2s_receiver` yields the same two words.
- **Underflow.** With no input, run 3 frames.
  - `sd` is constantly 0.
  - `underflow` pulses exactly once per left-frame start after sync.
- **Backpressure.** Present 6 words continuously with `tvalid=1`.
  - `tready` drops after 2 accepted beats.
  - It reasserts one clock after each left-frame start.
  - All 3 frames play in order with no loss.
- **Misalignment.** Send `tlast=1` as the first beat (0x1111_1111), then the correct pair 0x2222_2222 / 0x3333_3333.
  - `misalign` pulses once.
  - 0x1111_1111 never appears on `sd`.
  - The next frame plays 0x2222_2222 left and 0x3333_3333 right.
- **Reset mid-word.** Assert reset for 3 clocks at bit 15 of a left word.
  - `sd`=0 immediately.
  - After release, `sd` stays 0 until the next `ws` 1->0 transition.
  - A frame sent after release then plays correctly.

Source files
------------

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: buffers one stereo frame from an AXI-Stream slave and shifts it out
// MSB-first in Philips I2S format, framed by sck/ws from the shared controller.
module i2s_transmitter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  sck,
    input  logic                  ws,
    output logic                  sd,
    output logic                  underflow,
    output logic                  misalign
);
    typedef enum logic [1:0] {FILL_EMPTY, FILL_HALF, FILL_FULL} fill_t;

    fill_t fill, fill_nxt;

    logic                  rdy_en;
    logic                  sck_q;
    logic                  ws_last;
    logic                  synced;
    logic                  load_pending;
    logic                  load_right;
    logic [DATA_WIDTH-1:0] next_left, next_right;
    logic [DATA_WIDTH-1:0] play_left, play_right;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] load_word;

    logic fall, left_start, right_start, run, consume, hs;
    logic store_left, store_right, beat_err;

    assign fall        = sck_q & ~sck;
    assign left_start  = fall & ws_last & ~ws;
    assign right_start = fall & ~ws_last & ws;
    // The syncing left start is itself treated as a frame start.
    assign run         = fall & (synced | left_start);
    assign consume     = left_start & (fill == FILL_FULL);
    assign load_word   = load_right ? play_right : play_left;

    assign s_axis_tready = rdy_en & (fill != FILL_FULL);
    assign hs            = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            fill <= FILL_EMPTY;
        end else begin
            fill <= fill_nxt;
        end
    end

    // Handshakes only happen outside FULL, and consumption only inside it, so the
    // two never collide; a frame completing on a start cycle waits for the next one.
    always_comb begin
        fill_nxt    = fill;
        store_left  = 1'b0;
        store_right = 1'b0;
        beat_err    = 1'b0;
        case (fill)
            FILL_EMPTY: begin
                if (hs) begin
                    if (s_axis_tlast) begin
                        beat_err = 1'b1;
                    end else begin
                        store_left = 1'b1;
                        fill_nxt   = FILL_HALF;
                    end
                end
            end
            FILL_HALF: begin
                if (hs) begin
                    store_right = 1'b1;
                    beat_err    = ~s_axis_tlast;
                    fill_nxt    = FILL_FULL;
                end
            end
            FILL_FULL: begin
                if (consume) begin
                    fill_nxt = FILL_EMPTY;
                end
            end
            default: fill_nxt = FILL_EMPTY;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            rdy_en       <= 1'b0;
            sck_q        <= 1'b0;
            ws_last      <= 1'b0;
            synced       <= 1'b0;
            load_pending <= 1'b0;
            load_right   <= 1'b0;
            next_left    <= '0;
            next_right   <= '0;
            play_left    <= '0;
            play_right   <= '0;
            shreg        <= '0;
            sd           <= 1'b0;
            underflow    <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            sck_q     <= sck;
            underflow <= 1'b0;
            misalign  <= beat_err;

            if (store_left) begin
                next_left <= s_axis_tdata;
            end
            if (store_right) begin
                next_right <= s_axis_tdata;
            end
            if (fall) begin
                ws_last <= ws;
            end

            if (left_start) begin
                synced    <= 1'b1;
                underflow <= ~consume;
                if (consume) begin
                    play_left  <= next_left;
                    play_right <= next_right;
                end else begin
                    play_left  <= '0;
                    play_right <= '0;
                end
            end

            // A slot's MSB goes out one bit event after its ws edge (I2S one-bit delay).
            if (run) begin
                if (load_pending) begin
                    sd    <= load_word[DATA_WIDTH-1];
                    shreg <= load_word << 1;
                end else begin
                    sd    <= shreg[DATA_WIDTH-1];
                    shreg <= shreg << 1;
                end
                load_pending <= left_start | right_start;
                load_right   <= right_start;
            end
        end
    end
endmodule
